// File: rtl/serial_adder_param.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_param
//  Description : Bit-serial adder/subtractor. A single full-adder cell plus a
//                carry flop processes WIDTH-bit operands LSB first, one bit
//                per clock, with a start/busy/done handshake, carry-out and
//                signed-overflow reporting.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    // Counter must reach WIDTH-1 and never collapse to zero bits.
    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_s;
    logic               w_maj;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_next;

    // The one full-adder cell working on the current LSBs and the carry flop.
    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_maj  = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last = (r_cnt == c_last);

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    if (WIDTH == 1) begin : g_acc_w1
        assign w_acc_next = w_s;
    end else begin : g_acc_wn
        assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
    end

    // Control FSM, serial datapath and registered result/handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtract is A + ~B + 1, so the inversion and the
                        // forced carry are folded in at capture time.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_c     <= sub ? 1'b1 : carry_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_maj;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // r_c is still the carry into the MSB here.
                        r_sum   <= w_acc_next;
                        r_cout  <= w_maj;
                        r_ovf   <= r_c ^ w_maj;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_param
//  Description : Self-checking bench for serial_adder_param at WIDTH=8 and
//                WIDTH=2 against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic       cin8, sub8, cin2, sub2;
    logic       busy8, done8, cout8, ovf8;
    logic       busy2, done2, cout2, ovf2;
    logic [7:0] sum8;
    logic [1:0] sum2;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] prev_sum [2];
    logic        prev_cout[2];
    logic        prev_ovf [2];

    always #5 clk = ~clk;

    serial_adder_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .carry_in(cin8), .sub(sub8), .busy(busy8), .done(done8),
        .sum(sum8), .carry_out(cout8), .overflow(ovf8)
    );

    serial_adder_param #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .carry_in(cin2), .sub(sub2), .busy(busy2), .done(done2),
        .sum(sum2), .carry_out(cout2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain modular arithmetic: A + (sub ? -B : B) with carry, overflow from
    // operand/result sign agreement.
    function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                      input logic cin, input logic sb,
                                      output logic [63:0] s, output logic co, output logic ov);
        logic [63:0] mask;
        logic [63:0] ea, eb;
        logic [64:0] full;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        ea   = a & mask;
        eb   = (sb ? ~b : b) & mask;
        full = {1'b0, ea} + {1'b0, eb} + {64'd0, (sb ? 1'b1 : cin)};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (ea[w-1] == eb[w-1]) && (s[w-1] != ea[w-1]);
    endfunction

    task automatic drive(input int w, input logic s, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sb);
        if (w == 8) begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sb;
        end else begin
            start2 = s; a2 = a[1:0]; b2 = b[1:0]; cin2 = cin; sub2 = sb;
        end
    endtask

    function automatic logic o_busy(input int w);
        return (w == 8) ? busy8 : busy2;
    endfunction
    function automatic logic o_done(input int w);
        return (w == 8) ? done8 : done2;
    endfunction
    function automatic logic [63:0] o_sum(input int w);
        return (w == 8) ? {56'd0, sum8} : {62'd0, sum2};
    endfunction
    function automatic logic o_cout(input int w);
        return (w == 8) ? cout8 : cout2;
    endfunction
    function automatic logic o_ovf(input int w);
        return (w == 8) ? ovf8 : ovf2;
    endfunction

    // One full operation; inj=1 fires a competing start three cycles in.
    task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sb, input string tag, input bit inj);
        logic [63:0] es;
        logic        eco, eov;
        int          cyc, nbusy, idx, ndone;
        idx = (w == 8) ? 0 : 1;
        ref_model(w, a, b, cin, sb, es, eco, eov);
        @(negedge clk);
        drive(w, 1'b1, a, b, cin, sb);
        cyc   = 0;
        nbusy = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                drive(w, 1'b0, ~a, ~b, ~cin, ~sb);
                check({tag, ":hold_sum"}, o_sum(w), prev_sum[idx]);
                check({tag, ":hold_cout"}, o_cout(w), prev_cout[idx]);
            end
            if (inj && cyc == 3) drive(w, 1'b1, a ^ 64'h55, b ^ 64'hAA, 1'b1, 1'b1);
            if (inj && cyc == 4) drive(w, 1'b0, a, b, cin, sb);
            if (o_busy(w)) nbusy++;
            if (o_done(w)) break;
        end
        check({tag, ":latency"}, cyc, w + 1);
        check({tag, ":busy_cycles"}, nbusy, w + 1);
        check({tag, ":sum"}, o_sum(w), es);
        check({tag, ":cout"}, o_cout(w), eco);
        check({tag, ":ovf"}, o_ovf(w), eov);
        prev_sum[idx]  = es;
        prev_cout[idx] = eco;
        prev_ovf[idx]  = eov;
        @(negedge clk);
        check({tag, ":done_1cyc"}, o_done(w), 1'b0);
        check({tag, ":idle"}, o_busy(w), 1'b0);
        if (inj) begin
            ndone = 0;
            repeat (12) begin
                @(negedge clk);
                if (o_done(w)) ndone++;
            end
            check({tag, ":extra_done"}, ndone, 0);
            check({tag, ":sum_kept"}, o_sum(w), es);
        end
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0;
        drive(8, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        drive(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            prev_sum[i] = 64'd0; prev_cout[i] = 1'b0; prev_ovf[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst:busy8", busy8, 1'b0);
        check("rst:done8", done8, 1'b0);
        check("rst:sum8", sum8, 8'h00);
        check("rst:cout8", cout8, 1'b0);
        check("rst:ovf8", ovf8, 1'b0);
        check("rst:busy2", busy2, 1'b0);
        check("rst:sum2", sum2, 2'b00);
        repeat (3) @(negedge clk);
        check("idle:busy8", busy8, 1'b0);
        check("idle:done8", done8, 1'b0);

        do_op(8, 64'h0F, 64'h01, 1'b0, 1'b0, "add_0f_01", 1'b0);
        do_op(8, 64'hFF, 64'h01, 1'b1, 1'b0, "add_ff_01_c", 1'b0);
        do_op(8, 64'h7F, 64'h01, 1'b0, 1'b0, "add_7f_01", 1'b0);
        do_op(8, 64'h05, 64'h07, 1'b1, 1'b1, "sub_05_07", 1'b0);
        do_op(8, 64'h80, 64'h01, 1'b0, 1'b1, "sub_80_01", 1'b0);
        do_op(8, 64'h21, 64'h13, 1'b0, 1'b0, "ignore_start", 1'b1);

        // Abort: reset lands on the edge that processes bit 3.
        @(negedge clk);
        drive(8, 1'b1, 64'h3C, 64'h5A, 1'b0, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 64'h3C, 64'h5A, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort:busy", busy8, 1'b0);
        check("abort:done", done8, 1'b0);
        check("abort:sum", sum8, 8'h00);
        check("abort:cout", cout8, 1'b0);
        check("abort:ovf", ovf8, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            prev_sum[i] = 64'd0; prev_cout[i] = 1'b0; prev_ovf[i] = 1'b0;
        end
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort:no_done", ndone, 0);

        for (int n = 0; n < 40; n++) begin
            do_op(8, 64'($urandom_range(255)), 64'($urandom_range(255)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), "rand8", 1'b0);
        end

        for (int av = 0; av < 4; av++)
            for (int bv = 0; bv < 4; bv++)
                for (int c = 0; c < 2; c++)
                    for (int s = 0; s < 2; s++)
                        do_op(2, 64'(av), 64'(bv), 1'(c), 1'(s), "exh2", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
